// File: rtl/jump_target_unit.sv
// jump_target_unit: fetch-path jump-target generator with optional return-address stack.
// Build option: define JTU_RAS_EN to include the return-address stack (RAS).
//   Without it, mode 11 behaves as mode 10, linkIN/flushIN are ignored and
//   the stack flags are held at empty/not-full with no underflow.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   validIN               request strobe, one target per cycle while high
//   modeIN[1:0]           00 pseudo-direct, 01 PC-relative, 10 register, 11 return
//   irIN, pcIN, regIN     instruction register, PC, register operand
//   linkIN                push pcIN+PC_INC onto the RAS (qualified by validIN)
//   flushIN               synchronous RAS clear
//   validOUT, targetOUT   registered target and its valid (1-cycle latency)
//   rasEmptyOUT/FullOUT   RAS occupancy flags after the last edge
//   underflowOUT          one-cycle pulse on a pop from an empty RAS
module jump_target_unit #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned IMM_W     = 12,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned PC_INC    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              validIN,
  input  logic [1:0]        modeIN,
  input  logic [DATA_W-1:0] irIN,
  input  logic [DATA_W-1:0] pcIN,
  input  logic [DATA_W-1:0] regIN,
  input  logic              linkIN,
  input  logic              flushIN,
  output logic              validOUT,
  output logic [DATA_W-1:0] targetOUT,
  output logic              rasEmptyOUT,
  output logic              rasFullOUT,
  output logic              underflowOUT
);

  localparam logic [1:0] MODE_PD  = 2'b00;
  localparam logic [1:0] MODE_REL = 2'b01;
  localparam logic [1:0] MODE_REG = 2'b10;

  logic [DATA_W-1:0] w_direct;
  logic [DATA_W-1:0] w_rel;
  logic [DATA_W-1:0] w_ret_target;
  logic [DATA_W-1:0] w_target;
  logic              w_underflow;

  assign w_direct = {pcIN[DATA_W-1:IMM_W], irIN[IMM_W-1:0]};
  assign w_rel    = pcIN + {{(DATA_W-IMM_W){irIN[IMM_W-1]}}, irIN[IMM_W-1:0]};

`ifdef JTU_RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [DATA_W-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_empty;
  logic              r_full;

  logic [DATA_W-1:0] w_ret_addr;
  logic [PTR_W-1:0]  w_top_idx;
  logic [PTR_W-1:0]  w_wptr_nxt;
  logic [PTR_W-1:0]  w_wr_idx;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_pop;
  logic              w_push;
  logic              w_empty;
  logic              w_full;
  logic              w_wr_en;

  assign w_ret_addr   = pcIN + DATA_W'(PC_INC);
  assign w_top_idx    = r_wptr - PTR_W'(1);
  assign w_pop        = validIN && (modeIN == 2'b11);
  assign w_push       = validIN && linkIN;
  assign w_empty      = (r_cnt == '0);
  assign w_full       = (r_cnt == CNT_W'(RAS_DEPTH));
  assign w_ret_target = w_empty ? regIN : r_ras[w_top_idx];
  assign w_underflow  = w_pop && w_empty;

  // Stack pointer/count update; flush wins, pop+push on a live stack replaces the top in place
  always_comb begin
    w_wptr_nxt = r_wptr;
    w_cnt_nxt  = r_cnt;
    w_wr_en    = 1'b0;
    w_wr_idx   = r_wptr;
    if (flushIN) begin
      w_wptr_nxt = '0;
      w_cnt_nxt  = '0;
    end else if (w_push && w_pop && !w_empty) begin
      w_wr_en  = 1'b1;
      w_wr_idx = w_top_idx;
    end else if (w_push) begin
      // When full, the write pointer sits on the oldest entry, so it is overwritten
      w_wr_en    = 1'b1;
      w_wptr_nxt = r_wptr + PTR_W'(1);
      if (!w_full) w_cnt_nxt = r_cnt + CNT_W'(1);
    end else if (w_pop && !w_empty) begin
      w_wptr_nxt = w_top_idx;
      w_cnt_nxt  = r_cnt - CNT_W'(1);
    end
  end

  // RAS storage and registered occupancy flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RAS_DEPTH; i++) r_ras[PTR_W'(i)] <= '0;
      r_wptr  <= '0;
      r_cnt   <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_wr_en) r_ras[w_wr_idx] <= w_ret_addr;
      r_wptr  <= w_wptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_empty <= (w_cnt_nxt == '0);
      r_full  <= (w_cnt_nxt == CNT_W'(RAS_DEPTH));
    end
  end

  assign rasEmptyOUT = r_empty;
  assign rasFullOUT  = r_full;

  logic w_unused;
  assign w_unused = ^irIN[DATA_W-1:IMM_W];
`else
  assign w_ret_target = regIN;
  assign w_underflow  = 1'b0;
  assign rasEmptyOUT  = 1'b1;
  assign rasFullOUT   = 1'b0;

  logic w_unused;
  assign w_unused = ^{irIN[DATA_W-1:IMM_W], linkIN, flushIN, DATA_W'(PC_INC), DATA_W'(RAS_DEPTH)};
`endif

  // Target mux
  always_comb begin
    w_target = regIN;
    case (modeIN)
      MODE_PD:  w_target = w_direct;
      MODE_REL: w_target = w_rel;
      MODE_REG: w_target = regIN;
      default:  w_target = w_ret_target;
    endcase
  end

  // Output registers; target holds while no request is present
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validOUT     <= 1'b0;
      targetOUT    <= '0;
      underflowOUT <= 1'b0;
    end else begin
      validOUT     <= validIN;
      underflowOUT <= w_underflow;
      if (validIN) targetOUT <= w_target;
    end
  end

endmodule

// File: tb/tb_jump_target_unit.sv
// Scoreboard bench for jump_target_unit: a reference model pushes the expected
// outputs when a request is driven; a monitor pops and compares after the edge.
module tb_jump_target_unit;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned IMM_W     = 12;
  localparam int unsigned RAS_DEPTH = 4;
  localparam int unsigned PC_INC    = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              validIN;
  logic [1:0]        modeIN;
  logic [DATA_W-1:0] irIN;
  logic [DATA_W-1:0] pcIN;
  logic [DATA_W-1:0] regIN;
  logic              linkIN;
  logic              flushIN;
  logic              validOUT;
  logic [DATA_W-1:0] targetOUT;
  logic              rasEmptyOUT;
  logic              rasFullOUT;
  logic              underflowOUT;

  jump_target_unit #(
    .DATA_W(DATA_W), .IMM_W(IMM_W), .RAS_DEPTH(RAS_DEPTH), .PC_INC(PC_INC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .validIN(validIN), .modeIN(modeIN),
    .irIN(irIN), .pcIN(pcIN), .regIN(regIN), .linkIN(linkIN), .flushIN(flushIN),
    .validOUT(validOUT), .targetOUT(targetOUT), .rasEmptyOUT(rasEmptyOUT),
    .rasFullOUT(rasFullOUT), .underflowOUT(underflowOUT)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] t;
    logic              uf;
    logic              e;
    logic              f;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] m_stk[$];
  logic [DATA_W-1:0] m_tgt;
  int                n_vec = 0;
  int                n_err = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference model: stack held as a queue, newest entry at the back
  task automatic model(input logic v, input logic [1:0] m, input logic [DATA_W-1:0] ir,
                       input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] rg,
                       input logic lk, input logic fl, output exp_t e);
    logic [DATA_W-1:0] t;
    logic              uf;
    uf = 1'b0;
    case (m)
      2'd0:    t = {pc[DATA_W-1:IMM_W], ir[IMM_W-1:0]};
      2'd1:    t = pc + {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
      2'd2:    t = rg;
      default: begin
`ifdef JTU_RAS_EN
        if (m_stk.size() == 0) begin
          t  = rg;
          uf = 1'b1;
        end else begin
          t = m_stk[$];
        end
`else
        t = rg;
`endif
      end
    endcase
    if (v) m_tgt = t;
    else   uf = 1'b0;
`ifdef JTU_RAS_EN
    if (fl) begin
      m_stk.delete();
    end else if (v) begin
      if (m == 2'd3 && m_stk.size() > 0) void'(m_stk.pop_back());
      if (lk) begin
        m_stk.push_back(pc + DATA_W'(PC_INC));
        if (m_stk.size() > RAS_DEPTH) void'(m_stk.pop_front());
      end
    end
`endif
    e.v  = v;
    e.t  = m_tgt;
    e.uf = uf;
    e.e  = (m_stk.size() == 0);
    e.f  = (m_stk.size() == RAS_DEPTH);
  endtask

  // Monitor: compare the oldest expectation just after each rising edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("validOUT",     DATA_W'(validOUT),     DATA_W'(e.v));
      check("targetOUT",    targetOUT,             e.t);
      check("underflowOUT", DATA_W'(underflowOUT), DATA_W'(e.uf));
      check("rasEmptyOUT",  DATA_W'(rasEmptyOUT),  DATA_W'(e.e));
      check("rasFullOUT",   DATA_W'(rasFullOUT),   DATA_W'(e.f));
    end
  end

  task automatic step(input logic v, input logic [1:0] m, input logic [DATA_W-1:0] ir,
                      input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] rg,
                      input logic lk, input logic fl);
    exp_t e;
    @(negedge clk);
    validIN = v; modeIN = m; irIN = ir; pcIN = pc; regIN = rg; linkIN = lk; flushIN = fl;
    model(v, m, ir, pc, rg, lk, fl, e);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, DATA_W'(validOUT),     DATA_W'(0));
    check({tag, "_tgt"},   targetOUT,             DATA_W'(0));
    check({tag, "_uf"},    DATA_W'(underflowOUT), DATA_W'(0));
    check({tag, "_empty"}, DATA_W'(rasEmptyOUT),  DATA_W'(1));
    check({tag, "_full"},  DATA_W'(rasFullOUT),   DATA_W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    validIN = 1'b0; modeIN = 2'd0; irIN = '0; pcIN = '0; regIN = '0; linkIN = 1'b0; flushIN = 1'b0;
    m_stk.delete();
    m_tgt = '0;
    #3;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Modes 00/01
    step(1'b1, 2'd0, 16'h0ABC, 16'h5123, 16'h0000, 1'b0, 1'b0);
    check("tp1_pd", targetOUT, 16'h5ABC);
    check("tp1_v", DATA_W'(validOUT), DATA_W'(1));
    step(1'b1, 2'd1, 16'h0FFE, 16'h1000, 16'h0000, 1'b0, 1'b0);
    check("tp1_rel_neg", targetOUT, 16'h0FFE);
    step(1'b1, 2'd1, 16'h0010, 16'h1000, 16'h0000, 1'b0, 1'b0);
    check("tp1_rel_pos", targetOUT, 16'h1010);
    step(1'b1, 2'd1, 16'h0020, 16'hFFF0, 16'h0000, 1'b0, 1'b0);
    check("tp1_rel_wrap", targetOUT, 16'h0010);

`ifdef JTU_RAS_EN
    // Call / return
    step(1'b1, 2'd2, 16'h0000, 16'h0200, 16'h3000, 1'b1, 1'b0);
    check("tp2_call", targetOUT, 16'h3000);
    check("tp2_nonempty", DATA_W'(rasEmptyOUT), DATA_W'(0));
    step(1'b1, 2'd3, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("tp2_ret", targetOUT, 16'h0202);
    check("tp2_empty", DATA_W'(rasEmptyOUT), DATA_W'(1));

    // Overflow / underflow
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 2'd2, 16'h0000, DATA_W'(i * 16), 16'h0000, 1'b1, 1'b0);
      if (i == 4) check("tp3_full4", DATA_W'(rasFullOUT), DATA_W'(1));
    end
    check("tp3_full5", DATA_W'(rasFullOUT), DATA_W'(1));
    step(1'b1, 2'd3, 16'h0000, 16'h0000, 16'h7777, 1'b0, 1'b0);
    check("tp3_pop1", targetOUT, 16'h0052);
    step(1'b1, 2'd3, 16'h0000, 16'h0000, 16'h7777, 1'b0, 1'b0);
    check("tp3_pop2", targetOUT, 16'h0042);
    step(1'b1, 2'd3, 16'h0000, 16'h0000, 16'h7777, 1'b0, 1'b0);
    check("tp3_pop3", targetOUT, 16'h0032);
    step(1'b1, 2'd3, 16'h0000, 16'h0000, 16'h7777, 1'b0, 1'b0);
    check("tp3_pop4", targetOUT, 16'h0022);
    step(1'b1, 2'd3, 16'h0000, 16'h0000, 16'h7777, 1'b0, 1'b0);
    check("tp3_pop5", targetOUT, 16'h7777);
    check("tp3_uf", DATA_W'(underflowOUT), DATA_W'(1));
    check("tp3_empty", DATA_W'(rasEmptyOUT), DATA_W'(1));
    step(1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("tp3_uf_pulse", DATA_W'(underflowOUT), DATA_W'(0));

    // Simultaneous pop + push, then flush with pop
    step(1'b1, 2'd2, 16'h0000, 16'h0100, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 2'd3, 16'h0000, 16'h0400, 16'h0000, 1'b1, 1'b0);
    check("tp4_swap_tgt", targetOUT, 16'h0102);
    check("tp4_swap_cnt", DATA_W'(rasEmptyOUT), DATA_W'(0));
    step(1'b1, 2'd3, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("tp4_new_top", targetOUT, 16'h0402);
    check("tp4_one_left", DATA_W'(rasEmptyOUT), DATA_W'(1));
    step(1'b1, 2'd2, 16'h0000, 16'h0600, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 2'd2, 16'h0000, 16'h0700, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 2'd3, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    check("tp4_flush_tgt", targetOUT, 16'h0702);
    check("tp4_flush_empty", DATA_W'(rasEmptyOUT), DATA_W'(1));
    step(1'b1, 2'd3, 16'h0000, 16'h0000, 16'h5A5A, 1'b0, 1'b1);
    check("tp4_flush_uf", DATA_W'(underflowOUT), DATA_W'(1));

    // Reset between edges
    step(1'b1, 2'd2, 16'h0000, 16'h0800, 16'h1111, 1'b1, 1'b0);
    step(1'b1, 2'd2, 16'h0000, 16'h0900, 16'h2222, 1'b1, 1'b0);
    rst_n = 1'b0;
    m_stk.delete();
    m_tgt = '0;
    #1;
    check_reset_outputs("tp5");
    #1;
    rst_n = 1'b1;
    step(1'b1, 2'd3, 16'h0000, 16'h0000, 16'hABCD, 1'b0, 1'b0);
    check("tp5_ret_tgt", targetOUT, 16'hABCD);
    check("tp5_ret_uf", DATA_W'(underflowOUT), DATA_W'(1));

    // validIN gating
    step(1'b1, 2'd2, 16'h0000, 16'h0A00, 16'h1234, 1'b1, 1'b0);
    step(1'b0, 2'd3, 16'h0000, 16'h0B00, 16'h5555, 1'b1, 1'b0);
    check("tp6_hold", targetOUT, 16'h1234);
    check("tp6_v0", DATA_W'(validOUT), DATA_W'(0));
    step(1'b1, 2'd3, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("tp6_kept", targetOUT, 16'h0A02);
`else
    // Stack absent: return uses regIN and flags stay idle
    step(1'b1, 2'd3, 16'h0000, 16'h0200, 16'h4321, 1'b1, 1'b0);
    check("nr_ret", targetOUT, 16'h4321);
    check("nr_uf", DATA_W'(underflowOUT), DATA_W'(0));
    check("nr_empty", DATA_W'(rasEmptyOUT), DATA_W'(1));
    step(1'b1, 2'd3, 16'h0000, 16'h0300, 16'h8765, 1'b1, 1'b1);
    check("nr_ret2", targetOUT, 16'h8765);
    check("nr_full", DATA_W'(rasFullOUT), DATA_W'(0));
    step(1'b0, 2'd3, 16'h0000, 16'h0000, 16'h1111, 1'b1, 1'b0);
    check("nr_hold", targetOUT, 16'h8765);
    check("nr_v0", DATA_W'(validOUT), DATA_W'(0));
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic v;
      v = ($urandom_range(0, 9) < 8);
      step(v, 2'($urandom_range(0, 3)), DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom),
           ($urandom_range(0, 9) < 4), v && ($urandom_range(0, 29) == 0));
    end

    validIN = 1'b0; linkIN = 1'b0; flushIN = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
